// File: rtl/discrete_mixer_pkg.sv
// Shared types and constants for the discrete source mixer and related audio blocks.
// The accumulator width gives headroom so that a full sum of NUM_SOURCES products never wraps.
package discrete_mixer_pkg;

    localparam int SAMPLE_WIDTH = 16;
    localparam int SAMPLE_MAX   = 32767;
    localparam int SAMPLE_MIN   = -32768;

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        SAT
    } mixer_state_t;

    function automatic int acc_width(input int n, input int gw);
        return SAMPLE_WIDTH + gw + $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/mixer_saturator.sv
// Combinational arithmetic right shift followed by a clamp to a signed 16-bit sample.
// The shift floors toward -infinity; only the shifted value is clamped.
module mixer_saturator
    import discrete_mixer_pkg::*;
#(
    parameter int IN_W  = 27,
    parameter int SHIFT = 7
) (
    input  logic signed [IN_W-1:0]         din,
    output logic signed [SAMPLE_WIDTH-1:0] dout
);

    localparam logic signed [IN_W-1:0] MAX_C = IN_W'(SAMPLE_MAX);
    localparam logic signed [IN_W-1:0] MIN_C = IN_W'(SAMPLE_MIN);

    function automatic logic signed [SAMPLE_WIDTH-1:0] sat16(input logic signed [IN_W-1:0] v);
        if (v > MAX_C) begin
            return SAMPLE_WIDTH'(SAMPLE_MAX);
        end else if (v < MIN_C) begin
            return SAMPLE_WIDTH'(SAMPLE_MIN);
        end
        return v[SAMPLE_WIDTH-1:0];
    endfunction

    logic signed [IN_W-1:0] scaled;

    always_comb begin
        scaled = din >>> SHIFT;
        dout   = sat16(scaled);
    end

endmodule

// File: rtl/discrete_source_mixer.sv
// Time-multiplexed mixer: snapshots all sources on a sample tick, runs one MAC per clock,
// then scales and saturates the sum into a single signed 16-bit output sample.
module discrete_source_mixer
    import discrete_mixer_pkg::*;
#(
    parameter int NUM_SOURCES = 4,
    parameter int GAIN_WIDTH  = 8
) (
    input  logic                                clk,
    input  logic                                reset_n,
    input  logic                                audio_clk_en,
    input  logic [NUM_SOURCES*SAMPLE_WIDTH-1:0] in_samples,
    input  logic [NUM_SOURCES*GAIN_WIDTH-1:0]   gains,
    output logic [SAMPLE_WIDTH-1:0]             out,
    output logic                                out_valid,
    output logic                                busy,
    output logic                                overrun
);

    localparam int ACC_W  = acc_width(NUM_SOURCES, GAIN_WIDTH);
    localparam int IDX_W  = (NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1;
    localparam int PROD_W = SAMPLE_WIDTH + GAIN_WIDTH + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SOURCES - 1);

    mixer_state_t state, state_next;

    logic [IDX_W-1:0]               idx;
    logic signed [ACC_W-1:0]        acc;
    logic signed [SAMPLE_WIDTH-1:0] snap_sample [NUM_SOURCES];
    logic [GAIN_WIDTH-1:0]          snap_gain   [NUM_SOURCES];

    logic start;
    logic drop;

    logic signed [GAIN_WIDTH:0]     cur_gain;
    logic signed [PROD_W-1:0]       cur_prod;
    logic signed [SAMPLE_WIDTH-1:0] sat_out;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Ticks arriving in MAC or SAT (including the SAT->IDLE edge) are dropped, never queued.
    always_comb begin
        state_next = state;
        start      = 1'b0;
        drop       = 1'b0;
        case (state)
            IDLE: begin
                if (audio_clk_en) begin
                    start      = 1'b1;
                    state_next = MAC;
                end
            end
            MAC: begin
                drop = audio_clk_en;
                if (idx == LAST_IDX) begin
                    state_next = SAT;
                end
            end
            SAT: begin
                drop       = audio_clk_en;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Gain is zero-extended so the multiply stays signed without flipping large gains negative.
    always_comb begin
        cur_gain = signed'({1'b0, snap_gain[idx]});
        cur_prod = snap_sample[idx] * cur_gain;
    end

    mixer_saturator #(
        .IN_W  (ACC_W),
        .SHIFT (GAIN_WIDTH - 1)
    ) u_sat (
        .din  (acc),
        .dout (sat_out)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx       <= '0;
            acc       <= '0;
            out       <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            overrun   <= 1'b0;
            for (int i = 0; i < NUM_SOURCES; i++) begin
                snap_sample[i] <= '0;
                snap_gain[i]   <= '0;
            end
        end else begin
            busy      <= (state_next != IDLE);
            overrun   <= drop;
            out_valid <= (state == SAT);
            if (start) begin
                idx <= '0;
                acc <= '0;
                for (int i = 0; i < NUM_SOURCES; i++) begin
                    snap_sample[i] <= in_samples[SAMPLE_WIDTH*i +: SAMPLE_WIDTH];
                    snap_gain[i]   <= gains[GAIN_WIDTH*i +: GAIN_WIDTH];
                end
            end
            if (state == MAC) begin
                acc <= acc + ACC_W'(cur_prod);
                idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
            end
            if (state == SAT) begin
                out <= sat_out;
            end
        end
    end

endmodule

// File: tb/tb_discrete_source_mixer.sv
// Randomised and directed bench for discrete_source_mixer against an arithmetic reference model.
module tb_discrete_source_mixer;

    localparam int NS    = 4;
    localparam int GW    = 8;
    localparam int UNITY = 128;

    typedef int vec_t [NS];

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              audio_clk_en = 1'b0;
    logic [NS*16-1:0]  in_samples = '0;
    logic [NS*GW-1:0]  gains = '0;
    logic [15:0]       out;
    logic              out_valid;
    logic              busy;
    logic              overrun;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    discrete_source_mixer #(
        .NUM_SOURCES (NS),
        .GAIN_WIDTH  (GW)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .audio_clk_en (audio_clk_en),
        .in_samples   (in_samples),
        .gains        (gains),
        .out          (out),
        .out_valid    (out_valid),
        .busy         (busy),
        .overrun      (overrun)
    );

    // Reference: exact sum of products, floor-divided by the unity gain, then clamped.
    function automatic int model_mix(vec_t s, vec_t g);
        longint sum = 0;
        longint q;
        longint d = longint'(UNITY);
        for (int i = 0; i < NS; i++) sum += longint'(s[i]) * longint'(g[i]);
        if (sum >= 0) q = sum / d;
        else          q = -((-sum + d - 1) / d);
        if (q > 32767)  q = 32767;
        if (q < -32768) q = -32768;
        return int'(q);
    endfunction

    function automatic int out_int();
        return int'($signed(out));
    endfunction

    task automatic set_inputs(vec_t s, vec_t g);
        for (int i = 0; i < NS; i++) begin
            in_samples[16*i +: 16] = 16'(s[i]);
            gains[GW*i +: GW]      = GW'(g[i]);
        end
    endtask

    task automatic start_tick(vec_t s, vec_t g);
        @(negedge clk);
        set_inputs(s, g);
        audio_clk_en = 1'b1;
        @(posedge clk);
        #1 audio_clk_en = 1'b0;
    endtask

    task automatic wait_valid(output int cycles);
        cycles = -1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                cycles = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total_cnt++;
        if ({out, out_valid, busy, overrun} !== 19'd0)
            $display("FAIL reset_hold: out=%0d valid=%b busy=%b overrun=%b, required all 0",
                     out_int(), out_valid, busy, overrun);
        else pass_cnt++;
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk);
        #1;
        total_cnt++;
        if ({out, out_valid, busy, overrun} !== 19'd0)
            $display("FAIL reset_release: out=%0d valid=%b busy=%b overrun=%b, required all 0",
                     out_int(), out_valid, busy, overrun);
        else pass_cnt++;
    endtask

    task automatic test_unity_timing();
        vec_t s = '{1000, 0, 0, 0};
        vec_t g = '{UNITY, 0, 0, 0};
        start_tick(s, g);
        for (int k = 1; k <= NS + 1; k++) begin
            @(posedge clk);
            #1;
            total_cnt++;
            if (busy !== (k <= NS))
                $display("FAIL unity_busy_E%0d: busy=%b, required %b", k, busy, (k <= NS));
            else pass_cnt++;
            total_cnt++;
            if (out_valid !== (k == NS + 1))
                $display("FAIL unity_valid_E%0d: out_valid=%b, required %b", k, out_valid, (k == NS + 1));
            else pass_cnt++;
        end
        total_cnt++;
        if (out_int() !== model_mix(s, g))
            $display("FAIL unity_value: out=%0d, required %0d", out_int(), model_mix(s, g));
        else pass_cnt++;
        @(posedge clk);
        #1;
        total_cnt++;
        if (out_valid !== 1'b0)
            $display("FAIL unity_valid_fall: out_valid=%b, required 0", out_valid);
        else pass_cnt++;
    endtask

    task automatic test_saturation();
        vec_t s_tab [3] = '{'{20000, 20000, 20000, 20000},
                            '{-20000, -20000, -20000, -20000},
                            '{10000, 10000, 10000, 0}};
        vec_t g = '{UNITY, UNITY, UNITY, UNITY};
        int   exp_tab [3] = '{32767, -32768, 30000};
        int   cyc;
        for (int t = 0; t < 3; t++) begin
            start_tick(s_tab[t], g);
            wait_valid(cyc);
            total_cnt++;
            if (cyc < 0 || out_int() !== exp_tab[t] || out_int() !== model_mix(s_tab[t], g))
                $display("FAIL sat_case%0d: out=%0d (valid after %0d), required %0d", t, out_int(), cyc, exp_tab[t]);
            else pass_cnt++;
        end
    endtask

    task automatic test_fractional();
        vec_t s_tab [3] = '{'{-3, 0, 0, 0}, '{3, 0, 0, 0}, '{100, 0, 0, 0}};
        vec_t g_tab [3] = '{'{64, 0, 0, 0}, '{64, 0, 0, 0}, '{255, 0, 0, 0}};
        int   exp_tab [3] = '{-2, 1, 199};
        int   cyc;
        for (int t = 0; t < 3; t++) begin
            start_tick(s_tab[t], g_tab[t]);
            wait_valid(cyc);
            total_cnt++;
            if (cyc < 0 || out_int() !== exp_tab[t])
                $display("FAIL frac_case%0d: out=%0d (valid after %0d), required %0d", t, out_int(), cyc, exp_tab[t]);
            else pass_cnt++;
        end
    endtask

    task automatic test_snapshot();
        vec_t s = '{500, 0, 0, 0};
        vec_t g = '{UNITY, 0, 0, 0};
        int   cyc;
        start_tick(s, g);
        @(posedge clk);
        #1 in_samples[15:0] = 16'd7000;
        gains[GW-1:0] = 8'd255;
        wait_valid(cyc);
        total_cnt++;
        if (cyc < 0 || out_int() !== 500)
            $display("FAIL snapshot: out=%0d (valid after %0d), required 500", out_int(), cyc);
        else pass_cnt++;
    endtask

    task automatic test_overrun();
        vec_t s = '{1234, -2000, 300, 40};
        vec_t g = '{UNITY, 64, 200, 10};
        int   cyc;
        int   exp_val = model_mix(s, g);
        @(negedge clk);
        set_inputs(s, g);
        audio_clk_en = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 1; k <= 18; k++) begin
            @(posedge clk);
            #1;
            total_cnt++;
            if (out_valid !== (k % 6 == 5) || overrun !== (k % 6 != 0))
                $display("FAIL overrun_cycle%0d: valid=%b overrun=%b, required valid=%b overrun=%b",
                         k, out_valid, overrun, (k % 6 == 5), (k % 6 != 0));
            else pass_cnt++;
            if (k % 6 == 5) begin
                total_cnt++;
                if (out_int() !== exp_val)
                    $display("FAIL overrun_value%0d: out=%0d, required %0d", k, out_int(), exp_val);
                else pass_cnt++;
            end
        end
        @(negedge clk) audio_clk_en = 1'b0;
        wait_valid(cyc);
        total_cnt++;
        if (cyc < 0 || out_int() !== exp_val)
            $display("FAIL overrun_drain: out=%0d (valid after %0d), required %0d", out_int(), cyc, exp_val);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_mac();
        vec_t s1 = '{4000, 0, 0, 0};
        vec_t s2 = '{1000, 0, 0, 0};
        vec_t g  = '{UNITY, 0, 0, 0};
        int   cyc;
        int   seen = 0;
        start_tick(s1, g);
        @(posedge clk);
        @(posedge clk);
        #1 reset_n = 1'b0;
        #1;
        total_cnt++;
        if ({out, out_valid, busy, overrun} !== 19'd0)
            $display("FAIL midreset_outputs: out=%0d valid=%b busy=%b overrun=%b, required all 0",
                     out_int(), out_valid, busy, overrun);
        else pass_cnt++;
        repeat (2) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        total_cnt++;
        if (seen != 0 || out_int() !== 0)
            $display("FAIL midreset_no_valid: valid_pulses=%0d out=%0d, required 0 and 0", seen, out_int());
        else pass_cnt++;
        start_tick(s2, g);
        wait_valid(cyc);
        total_cnt++;
        if (cyc != NS + 1 || out_int() !== 1000)
            $display("FAIL midreset_recover: out=%0d valid after %0d, required 1000 after %0d", out_int(), cyc, NS + 1);
        else pass_cnt++;
    endtask

    task automatic test_random();
        vec_t s;
        vec_t g;
        int   cyc;
        for (int t = 0; t < 25; t++) begin
            for (int i = 0; i < NS; i++) begin
                s[i] = int'($urandom_range(0, 65535)) - 32768;
                g[i] = int'($urandom_range(0, 255));
            end
            if (t % 5 == 0) g[t % NS] = 0;
            start_tick(s, g);
            wait_valid(cyc);
            total_cnt++;
            if (cyc != NS + 1 || out_int() !== model_mix(s, g))
                $display("FAIL random%0d: out=%0d valid after %0d, required %0d after %0d",
                         t, out_int(), cyc, model_mix(s, g), NS + 1);
            else pass_cnt++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_unity_timing();
        test_saturation();
        test_fractional();
        test_snapshot();
        test_overrun();
        test_reset_mid_mac();
        test_random();
        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
